upsp_frame_ctrl: RTL and testbench
==================================

UPSP_FRAME_CTRL -- requirements
Module: upsp_frame_ctrl

Interface
REQ-001 SHALL have parameter CRF_DATA_WIDTH, default 32, config register data width.
REQ-002 SHALL have parameter CRF_ADDR_WIDTH, default 4, config register address width.
REQ-003 SHALL have parameters SRC_IMG_WIDTH / SRC_IMG_HEIGHT, defaults 960 / 540, source frame size in pixels.
REQ-004 SHALL have parameters DST_IMG_WIDTH / DST_IMG_HEIGHT, defaults 3840 / 2160, destination frame size in pixels.
REQ-005 SHALL have parameter UPENDR_ADDR, default 4'h1, CRF address of the end/status register.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit between write beats.
REQ-007 SHALL have one clock and an asynchronous active-low reset, as follows: clk  in  1  sole clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 crf_ac_UPSTR  in  CRF_DATA_WIDTH  start register; bit0 = start request.
REQ-010 crf_ac_wbusy  in  1  CRF cannot accept an internal write this cycle.
REQ-011 upsp_ac_rd / ac_upsp_rvalid  in  1 each  source read beat = both high.
REQ-012 upsp_ac_wrt / ac_upsp_wready  in  1 each  destination write beat = both high.
REQ-013 upsp_en  out  1  enables bicubic datapath for the current frame.
REQ-014 ctrl_crf_wrt / ctrl_crf_waddr / ctrl_crf_wdata  out  1 / CRF_ADDR_WIDTH / CRF_DATA_WIDTH  status write to CRF.
REQ-015 dst_col / dst_row  out  clog2(DST_IMG_WIDTH) / clog2(DST_IMG_HEIGHT)  position of next destination pixel.
REQ-016 frame_busy / frame_err  out  1 each  frame in progress / last frame failed.

Function
REQ-017 SHALL implement states IDLE, RUN, REPORT; reset state IDLE.
REQ-018 Start = rising edge of crf_ac_UPSTR[0] (registered previous value); start sampled in IDLE at cycle N -> RUN, upsp_en=1, frame_busy=1 at N+1.
REQ-019 On IDLE->RUN SHALL clear src count, dst col/row, dst count, watchdog, frame_err.
REQ-020 Start edges in RUN or REPORT SHALL be ignored; no queuing.
REQ-021 Read beats in RUN SHALL increment src count (width clog2(SRC_W*SRC_H+1)); a read beat when count already = SRC_W*SRC_H SHALL set error and go to REPORT.
REQ-022 Write beats in RUN SHALL advance dst_col; at DST_IMG_WIDTH-1 wrap to 0 and increment dst_row.
REQ-023 Simultaneous read and write beats in one cycle SHALL both be counted.
REQ-024 Write beat at row DST_H-1, col DST_W-1 in cycle M SHALL move to REPORT; upsp_en=0 and ctrl_crf_wrt=1 at M+1; dst_col/dst_row wrap to 0.
REQ-025 Watchdog SHALL count RUN cycles with no write beat, clear on each write beat; on reaching TIMEOUT_CYCLES set error and go to REPORT.
REQ-026 In REPORT: ctrl_crf_wrt=1, ctrl_crf_waddr=UPENDR_ADDR, ctrl_crf_wdata bit0=1 (done), bit1=error, other bits 0; held stable until a cycle with crf_ac_wbusy=0.
REQ-027 Write accepted (ctrl_crf_wrt && !crf_ac_wbusy) SHALL return to IDLE next cycle, ctrl_crf_wrt=0, frame_busy=0; frame_err holds error until next start.
REQ-028 Beats outside RUN SHALL not change any counter.
REQ-029 upsp_en SHALL be 1 only in RUN.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and all outputs, counters, watchdog and start-edge register to 0, including mid-frame and mid-REPORT.
REQ-031 After rst_n release, a crf_ac_UPSTR[0] already high SHALL not start a frame; a 0->1 edge is required.

Verification (SRC 4x2, DST 16x8, TIMEOUT_CYCLES 64)
REQ-032 Start edge, 8 reads, 128 writes with wready=1 -> upsp_en 1 cycle after start, dst_row/dst_col sweep 0..7/0..15, ctrl_crf_wrt one cycle after 128th beat, wdata=0x1, frame_err=0.
REQ-033 Same with crf_ac_wbusy=1 for 5 cycles in REPORT -> ctrl_crf_wrt/waddr/wdata stable 6 cycles, IDLE after acceptance.
REQ-034 Start, 10 writes then no beats -> REPORT after 64 idle cycles, wdata=0x3, frame_err=1.
REQ-035 Start, 9th read beat -> REPORT, wdata=0x3; second start edge during RUN -> no counter reset.
REQ-036 rst_n pulse at write 50 -> all outputs 0 asynchronously; UPSTR held high -> stays IDLE until 0->1 edge.
REQ-037 Read and write beats in the same cycle, and beats while IDLE -> counted once each in RUN, none in IDLE.

Source files
------------

// File: rtl/upsp_frame_ctrl_if.sv
// Handshake and status bundle between the upscaler frame controller and its
// CRF / source-read / destination-write neighbours.
interface upsp_frame_ctrl_if #(
    parameter int CRF_DATA_WIDTH = 32,
    parameter int CRF_ADDR_WIDTH = 4,
    parameter int DST_IMG_WIDTH  = 3840,
    parameter int DST_IMG_HEIGHT = 2160
);
    logic [CRF_DATA_WIDTH-1:0]         crf_ac_UPSTR;
    logic                              crf_ac_wbusy;
    logic                              upsp_ac_rd;
    logic                              ac_upsp_rvalid;
    logic                              upsp_ac_wrt;
    logic                              ac_upsp_wready;
    logic                              upsp_en;
    logic                              ctrl_crf_wrt;
    logic [CRF_ADDR_WIDTH-1:0]         ctrl_crf_waddr;
    logic [CRF_DATA_WIDTH-1:0]         ctrl_crf_wdata;
    logic [$clog2(DST_IMG_WIDTH)-1:0]  dst_col;
    logic [$clog2(DST_IMG_HEIGHT)-1:0] dst_row;
    logic                              frame_busy;
    logic                              frame_err;

    modport master (
        input  crf_ac_UPSTR, crf_ac_wbusy, upsp_ac_rd, ac_upsp_rvalid,
               upsp_ac_wrt, ac_upsp_wready,
        output upsp_en, ctrl_crf_wrt, ctrl_crf_waddr, ctrl_crf_wdata,
               dst_col, dst_row, frame_busy, frame_err
    );

    modport slave (
        output crf_ac_UPSTR, crf_ac_wbusy, upsp_ac_rd, ac_upsp_rvalid,
               upsp_ac_wrt, ac_upsp_wready,
        input  upsp_en, ctrl_crf_wrt, ctrl_crf_waddr, ctrl_crf_wdata,
               dst_col, dst_row, frame_busy, frame_err
    );
endinterface

// File: rtl/upsp_frame_ctrl.sv
// Per-frame sequencer for the bicubic upscaler: starts on a CRF start edge,
// tracks source reads and destination pixel position, reports done/error.
module upsp_frame_ctrl #(
    parameter int                        CRF_DATA_WIDTH = 32,
    parameter int                        CRF_ADDR_WIDTH = 4,
    parameter int                        SRC_IMG_WIDTH  = 960,
    parameter int                        SRC_IMG_HEIGHT = 540,
    parameter int                        DST_IMG_WIDTH  = 3840,
    parameter int                        DST_IMG_HEIGHT = 2160,
    parameter logic [CRF_ADDR_WIDTH-1:0] UPENDR_ADDR    = 4'h1,
    parameter int                        TIMEOUT_CYCLES = 65535
) (
    input logic               clk,
    input logic               rst_n,
    upsp_frame_ctrl_if.master bus
);
    localparam int COL_W     = $clog2(DST_IMG_WIDTH);
    localparam int ROW_W     = $clog2(DST_IMG_HEIGHT);
    localparam int SRC_TOTAL = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
    localparam int SRC_W     = $clog2(SRC_TOTAL + 1);
    localparam int WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SRC_W-1:0]  SRC_FULL  = SRC_W'(SRC_TOTAL);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_d;
    logic                r_armed;
    logic [SRC_W-1:0]    r_src_cnt;
    logic [COL_W-1:0]    r_dst_col;
    logic [ROW_W-1:0]    r_dst_row;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_err;

    logic w_run, w_start, w_rd_beat, w_wr_beat, w_src_ovf, w_last_px, w_timeout;
    logic w_clear, w_set_err;
    logic w_unused_upstr;

    assign w_unused_upstr = ^bus.crf_ac_UPSTR[CRF_DATA_WIDTH-1:1];

    // r_armed stays low for the first clock after reset so that a start bit
    // already high at release is seen as a level, not as a fresh edge.
    assign w_start   = r_armed & bus.crf_ac_UPSTR[0] & ~r_start_d;
    assign w_run     = (r_state == S_RUN);
    assign w_rd_beat = w_run & bus.upsp_ac_rd & bus.ac_upsp_rvalid;
    assign w_wr_beat = w_run & bus.upsp_ac_wrt & bus.ac_upsp_wready;
    assign w_src_ovf = w_rd_beat & (r_src_cnt == SRC_FULL);
    assign w_last_px = w_wr_beat & (r_dst_col == COL_LAST) & (r_dst_row == ROW_LAST);
    assign w_timeout = w_run & ~w_wr_beat & (r_wdog == WDOG_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= bus.crf_ac_UPSTR[0];
            r_armed   <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_src_ovf || w_timeout) begin
                    w_state_nxt = S_REPORT;
                    w_set_err   = 1'b1;
                end else if (w_last_px) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (!bus.crf_ac_wbusy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_cnt <= '0;
            r_dst_col <= '0;
            r_dst_row <= '0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
        end else if (w_clear) begin
            r_src_cnt <= '0;
            r_dst_col <= '0;
            r_dst_row <= '0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
        end else if (w_run) begin
            if (w_rd_beat && !w_src_ovf) r_src_cnt <= r_src_cnt + SRC_W'(1);
            if (w_wr_beat) begin
                r_wdog <= '0;
                if (r_dst_col == COL_LAST) begin
                    r_dst_col <= '0;
                    r_dst_row <= (r_dst_row == ROW_LAST) ? '0 : r_dst_row + ROW_W'(1);
                end else begin
                    r_dst_col <= r_dst_col + COL_W'(1);
                end
            end else if (!w_timeout) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_set_err) r_err <= 1'b1;
        end
    end

    always_comb begin
        bus.upsp_en        = w_run;
        bus.frame_busy     = (r_state != S_IDLE);
        bus.ctrl_crf_wrt   = (r_state == S_REPORT);
        bus.ctrl_crf_waddr = '0;
        bus.ctrl_crf_wdata = '0;
        if (r_state == S_REPORT) begin
            bus.ctrl_crf_waddr    = UPENDR_ADDR;
            bus.ctrl_crf_wdata[0] = 1'b1;
            bus.ctrl_crf_wdata[1] = r_err;
        end
    end

    assign bus.dst_col   = r_dst_col;
    assign bus.dst_row   = r_dst_row;
    assign bus.frame_err = r_err;
endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Directed bench for upsp_frame_ctrl with a 4x2 source, 16x8 destination and
// a 64-cycle watchdog.
module tb_upsp_frame_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    upsp_frame_ctrl_if #(
        .CRF_DATA_WIDTH(DW), .CRF_ADDR_WIDTH(AW),
        .DST_IMG_WIDTH(16), .DST_IMG_HEIGHT(8)
    ) bus ();

    upsp_frame_ctrl #(
        .CRF_DATA_WIDTH(DW), .CRF_ADDR_WIDTH(AW),
        .SRC_IMG_WIDTH(4), .SRC_IMG_HEIGHT(2),
        .DST_IMG_WIDTH(16), .DST_IMG_HEIGHT(8),
        .UPENDR_ADDR(4'h1), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic upstr, rd, rvalid, wrt, wready;
        logic en, busy;
        int   col;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.crf_ac_UPSTR = '0;
        step();
        bus.crf_ac_UPSTR = 32'h1;
        step();
        check("start_en",   bus.upsp_en,    1);
        check("start_busy", bus.frame_busy, 1);
        check("start_err",  bus.frame_err,  0);
        check("start_pos",  {bus.dst_row, bus.dst_col}, 0);
    endtask

    task automatic write_beats(input int n, input int n_reads);
        for (int i = 0; i < n; i++) begin
            check("pos", {bus.dst_row, bus.dst_col}, i);
            bus.upsp_ac_wrt    = 1'b1;
            bus.ac_upsp_wready = 1'b1;
            bus.upsp_ac_rd     = (i < n_reads);
            bus.ac_upsp_rvalid = 1'b1;
            step();
        end
        bus.upsp_ac_wrt = 1'b0;
        bus.upsp_ac_rd  = 1'b0;
    endtask

    task automatic check_report(input string tag, input int wdata);
        check({tag, "_wrt"},   bus.ctrl_crf_wrt,   1);
        check({tag, "_waddr"}, bus.ctrl_crf_waddr, 1);
        check({tag, "_wdata"}, bus.ctrl_crf_wdata, wdata);
        check({tag, "_en"},    bus.upsp_en,        0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    bus.upsp_en,        0);
        check({tag, "_busy"},  bus.frame_busy,     0);
        check({tag, "_wrt"},   bus.ctrl_crf_wrt,   0);
        check({tag, "_waddr"}, bus.ctrl_crf_waddr, 0);
        check({tag, "_wdata"}, bus.ctrl_crf_wdata, 0);
        check({tag, "_pos"},   {bus.dst_row, bus.dst_col}, 0);
        check({tag, "_err"},   bus.frame_err,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        //           upstr rd rv wr wrdy | en busy col
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0}; // armed, idle
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0}; // beats in idle ignored
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0}; // start edge, beats still idle
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1}; // no wready, no beat
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2}; // read + write together
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2}; // start edge during run
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3};

        bus.crf_ac_UPSTR   = '0;
        bus.crf_ac_wbusy   = 1'b0;
        bus.upsp_ac_rd     = 1'b0;
        bus.ac_upsp_rvalid = 1'b0;
        bus.upsp_ac_wrt    = 1'b0;
        bus.ac_upsp_wready = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            bus.crf_ac_UPSTR   = {31'b0, vecs[v].upstr};
            bus.upsp_ac_rd     = vecs[v].rd;
            bus.ac_upsp_rvalid = vecs[v].rvalid;
            bus.upsp_ac_wrt    = vecs[v].wrt;
            bus.ac_upsp_wready = vecs[v].wready;
            step();
            check($sformatf("vec%0d_en", v),   bus.upsp_en,    vecs[v].en);
            check($sformatf("vec%0d_busy", v), bus.frame_busy, vecs[v].busy);
            check($sformatf("vec%0d_col", v),  bus.dst_col,    vecs[v].col);
            check($sformatf("vec%0d_row", v),  bus.dst_row,    0);
        end

        // One read counted so far; seven more fill the source, the ninth overflows.
        bus.upsp_ac_wrt    = 1'b0;
        bus.upsp_ac_rd     = 1'b1;
        bus.ac_upsp_rvalid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("fill_en", bus.upsp_en, 1);
        end
        step();
        bus.upsp_ac_rd = 1'b0;
        check_report("ovf", 3);
        check("ovf_err", bus.frame_err, 1);
        check("ovf_col", bus.dst_col, 3);
        step();
        check("ovf_idle_busy", bus.frame_busy,   0);
        check("ovf_idle_wrt",  bus.ctrl_crf_wrt, 0);
        check("ovf_err_held",  bus.frame_err,    1);

        // Full clean frame, immediate acceptance.
        start_frame();
        write_beats(128, 8);
        check_report("done", 1);
        check("done_err",  bus.frame_err,  0);
        check("done_busy", bus.frame_busy, 1);
        check("done_pos",  {bus.dst_row, bus.dst_col}, 0);
        step();
        check("done_idle_busy", bus.frame_busy,   0);
        check("done_idle_wrt",  bus.ctrl_crf_wrt, 0);

        // Full frame with the CRF busy for five REPORT cycles.
        start_frame();
        bus.crf_ac_wbusy = 1'b1;
        write_beats(128, 8);
        for (int k = 1; k <= 6; k++) begin
            check_report($sformatf("hold%0d", k), 1);
            if (k == 6) bus.crf_ac_wbusy = 1'b0;
            step();
        end
        check("hold_idle_busy", bus.frame_busy,   0);
        check("hold_idle_wrt",  bus.ctrl_crf_wrt, 0);

        // Watchdog: ten writes, then 64 beat-free cycles.
        start_frame();
        write_beats(10, 0);
        for (int i = 0; i < 63; i++) step();
        check("wdog_63_en", bus.upsp_en, 1);
        step();
        check_report("wdog", 3);
        check("wdog_err", bus.frame_err, 1);
        check("wdog_col", bus.dst_col, 10);
        bus.crf_ac_wbusy = 1'b1;
        step();
        check("wdog_hold_wrt", bus.ctrl_crf_wrt, 1);

        // Asynchronous reset while stuck in REPORT.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_report");
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.crf_ac_wbusy = 1'b0;

        // Asynchronous reset after 50 writes, start bit held high throughout.
        start_frame();
        write_beats(50, 0);
        check("mid_pos", {bus.dst_row, bus.dst_col}, 50);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_high_busy", bus.frame_busy, 0);
        end
        bus.crf_ac_UPSTR = '0;
        step();
        bus.crf_ac_UPSTR = 32'h1;
        step();
        check("restart_en", bus.upsp_en, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
